control_sequencer: RTL and testbench

- Microsequencer directly upstream of the processor's shared data bus.
- Fetches instructions from instruction memory into IR, decodes them, and issues one bus transfer per cycle. A transfer is a source select on read_en plus a destination select on write_en.
- Also drives the ALU opcode, the PC increment, and the memory strobes.
- read_en uses the bus source encoding. write_en reuses the same code space for destinations.

---
 rtl/control_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microsequencer ahead of the shared data bus. It fetches an instruction
//   into IR, decodes it, then issues at most one bus transfer per cycle
//   (a source select on read_en plus a destination select on write_en).
//   It also drives the ALU opcode, the PC increment and the memory strobes.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   ir         in   [15:0] instruction register contents
//   z_flag     in   ALU zero flag, sampled by the JZ decode in EXEC1
//   read_en    out  [3:0] bus source select (0 = none)
//   write_en   out  [3:0] bus destination select (0 = none, 12 = DM write)
//   alu_op     out  [ALUW-1:0] ALU operation (0 when idle)
//   alu_ld     out  AC loads the ALU result instead of the bus
//   pc_inc     out  PC increments at the end of this cycle
//   im_rd      out  instruction memory read strobe (address = PC)
//   dm_rd      out  data memory read strobe (address = DAR)
//   instr_done out  pulse in the last cycle of each instruction
//   halted     out  high while in HALT
module control_sequencer #(
  parameter int OPW  = 4,
  parameter int ALUW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     ir,
  input  logic            z_flag,
  output logic [3:0]      read_en,
  output logic [3:0]      write_en,
  output logic [ALUW-1:0] alu_op,
  output logic            alu_ld,
  output logic            pc_inc,
  output logic            im_rd,
  output logic            dm_rd,
  output logic            instr_done,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_e;

  typedef enum logic [OPW-1:0] {
    OP_NOP = 'h0,
    OP_LDI = 'h1,
    OP_MOV = 'h2,
    OP_STM = 'h3,
    OP_LDM = 'h4,
    OP_ALU = 'h5,
    OP_JMP = 'h6,
    OP_JZ  = 'h7,
    OP_HLT = 'hF
  } op_e;

  typedef enum logic [3:0] {
    BUS_NONE = 4'd0,
    BUS_PC   = 4'd1,
    BUS_DAR  = 4'd2,
    BUS_IR   = 4'd4,
    BUS_AC   = 4'd5,
    BUS_R    = 4'd6,
    BUS_R1   = 4'd7,
    BUS_R5   = 4'd11,
    BUS_DM   = 4'd12,
    BUS_IM   = 4'd13
  } bus_e;

  state_e          state_q, state_d;
  op_e             op;
  logic [3:0]      src, dst;
  logic            src_ok, dst_ok;
  logic            two_exec;
  logic            unused_ir;

  assign op        = op_e'(ir[15 -: OPW]);
  assign src       = ir[3:0];
  assign dst       = ir[7:4];
  assign unused_ir = ir[11];

  assign src_ok = (src == BUS_PC) || (src == BUS_DAR) ||
                  ((src >= BUS_IR) && (src <= BUS_IM));
  assign dst_ok = (dst == BUS_PC) || (dst == BUS_DAR) ||
                  ((dst >= BUS_AC) && (dst <= BUS_R5));

  assign two_exec = (op == OP_LDM) || (op == OP_ALU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: state_d = (op == OP_HLT) ? S_HALT : S_EXEC1;
      S_EXEC1:  state_d = two_exec ? S_EXEC2 : S_FETCH1;
      S_EXEC2:  state_d = S_FETCH1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore decode from state and ir; IDLE (held during reset) drives all zeros,
  // so an asynchronous reset clears every strobe without waiting for clk.
  always_comb begin
    read_en    = '0;
    write_en   = '0;
    alu_op     = '0;
    alu_ld     = 1'b0;
    pc_inc     = 1'b0;
    im_rd      = 1'b0;
    dm_rd      = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      S_FETCH1: im_rd = 1'b1;
      S_FETCH2: begin
        read_en  = BUS_IM;
        write_en = BUS_IR;
        pc_inc   = 1'b1;
      end
      S_EXEC1: begin
        instr_done = !two_exec;
        case (op)
          OP_LDI: begin
            read_en  = BUS_IR;
            write_en = BUS_AC;
          end
          // src == dst would put the same code on both selects; treat as NOP.
          OP_MOV: if (src_ok && dst_ok && (src != dst)) begin
            read_en  = src;
            write_en = dst;
          end
          OP_STM: begin
            read_en  = BUS_AC;
            write_en = BUS_DM;
          end
          OP_LDM: dm_rd = 1'b1;
          OP_ALU: if (src_ok) begin
            read_en = src;
            alu_op  = ir[8 +: ALUW];
          end
          OP_JMP: begin
            read_en  = BUS_IR;
            write_en = BUS_PC;
          end
          OP_JZ: if (z_flag) begin
            read_en  = BUS_IR;
            write_en = BUS_PC;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        instr_done = 1'b1;
        if (op == OP_LDM) begin
          read_en  = BUS_DM;
          write_en = BUS_AC;
        end else if (op == OP_ALU && src_ok) begin
          alu_op   = ir[8 +: ALUW];
          alu_ld   = 1'b1;
          write_en = BUS_AC;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ir;
  logic        z_flag;
  logic [3:0]  read_en, write_en;
  logic [2:0]  alu_op;
  logic        alu_ld, pc_inc, im_rd, dm_rd, instr_done, halted;

  int unsigned errors = 0;
  int unsigned checks = 0;

  control_sequencer #(.OPW(4), .ALUW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir         (ir),
    .z_flag     (z_flag),
    .read_en    (read_en),
    .write_en   (write_en),
    .alu_op     (alu_op),
    .alu_ld     (alu_ld),
    .pc_inc     (pc_inc),
    .im_rd      (im_rd),
    .dm_rd      (dm_rd),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected fields: re, we, aop, {alu_ld, pc_inc, im_rd, dm_rd, instr_done, halted}
  task automatic check(input string tag, input logic [3:0] re, input logic [3:0] we,
                       input logic [2:0] aop, input logic [5:0] fl);
    logic [16:0] obs, exp;
    obs = {read_en, write_en, alu_op, alu_ld, pc_inc, im_rd, dm_rd, instr_done, halted};
    exp = {re, we, aop, fl};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed re=%0d we=%0d aop=%0d flags=%b expected re=%0d we=%0d aop=%0d flags=%b",
             tag, obs[16:13], obs[12:9], obs[8:6], obs[5:0], re, we, aop, fl);
    end
  endtask

  // Precondition: state is FETCH1. Leaves the bench in EXEC1.
  task automatic fetch_decode(input string tag);
    check({tag, ".fetch1"}, 4'd0, 4'd0, 3'd0, 6'b001000);
    tick();
    check({tag, ".fetch2"}, 4'd13, 4'd4, 3'd0, 6'b010000);
    tick();
    check({tag, ".decode"}, 4'd0, 4'd0, 3'd0, 6'b000000);
    tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    ir     = 16'h0000;
    z_flag = 1'b0;
    tick();
    tick();
    check("reset", 4'd0, 4'd0, 3'd0, 6'b000000);

    @(negedge clk);
    rst_n = 1'b1;
    tick();                               // IDLE -> FETCH1
    fetch_decode("nop");
    check("nop.exec1", 4'd0, 4'd0, 3'd0, 6'b000010);
    tick();

    ir = 16'h2079;                        // MOV R3 -> R1
    fetch_decode("mov");
    check("mov.exec1", 4'd9, 4'd7, 3'd0, 6'b000010);
    tick();

    ir = 16'h20E9;                        // MOV with illegal dst 14
    fetch_decode("mov_bad");
    check("mov_bad.exec1", 4'd0, 4'd0, 3'd0, 6'b000010);
    tick();

    ir = 16'h1000;                        // LDI
    fetch_decode("ldi");
    check("ldi.exec1", 4'd4, 4'd5, 3'd0, 6'b000010);
    tick();

    ir = 16'h3000;                        // STM
    fetch_decode("stm");
    check("stm.exec1", 4'd5, 4'd12, 3'd0, 6'b000010);
    tick();

    ir = 16'h4000;                        // LDM
    fetch_decode("ldm");
    check("ldm.exec1", 4'd0, 4'd0, 3'd0, 6'b000100);
    tick();
    check("ldm.exec2", 4'd12, 4'd5, 3'd0, 6'b000010);
    tick();

    ir = 16'h5307;                        // ALU op 3, src R1
    fetch_decode("alu");
    check("alu.exec1", 4'd7, 4'd0, 3'd3, 6'b000000);
    tick();
    check("alu.exec2", 4'd0, 4'd5, 3'd3, 6'b100010);
    tick();

    ir = 16'h6000;                        // JMP
    fetch_decode("jmp");
    check("jmp.exec1", 4'd4, 4'd1, 3'd0, 6'b000010);
    tick();

    ir = 16'h7000;                        // JZ taken
    z_flag = 1'b1;
    fetch_decode("jz1");
    check("jz1.exec1", 4'd4, 4'd1, 3'd0, 6'b000010);
    tick();

    z_flag = 1'b0;                        // JZ not taken
    fetch_decode("jz0");
    check("jz0.exec1", 4'd0, 4'd0, 3'd0, 6'b000010);
    tick();

    ir = 16'h9000;                        // reserved opcode
    fetch_decode("rsv");
    check("rsv.exec1", 4'd0, 4'd0, 3'd0, 6'b000010);
    tick();

    ir = 16'h4000;                        // LDM interrupted in EXEC2
    fetch_decode("ldm_rst");
    tick();
    check("ldm_rst.exec2", 4'd12, 4'd5, 3'd0, 6'b000010);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'd0, 4'd0, 3'd0, 6'b000000);
    tick();
    check("reset_hold", 4'd0, 4'd0, 3'd0, 6'b000000);

    @(negedge clk);
    ir    = 16'hF000;
    rst_n = 1'b1;
    tick();                               // IDLE -> FETCH1
    fetch_decode("halt");
    for (int unsigned i = 0; i < 22; i++) begin
      check("halt.hold", 4'd0, 4'd0, 3'd0, 6'b000001);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
